// File: rtl/pill_pkg.sv
// pill_pkg: shared types and constants for the pill-bottling line.
//   state_t : sequencer state codes (values match the display codes)
//   beep_t  : beeper pattern codes
//   widths  : pill counter, bottle counter and watchdog timer widths
package pill_pkg;

    localparam int PILL_W   = 10;
    localparam int BOTTLE_W = 7;
    localparam int TIMER_W  = 4;

    // Highest pill count the display can show; the pill counter stops here.
    localparam logic [PILL_W-1:0] PILL_MAX = 10'd999;

    typedef enum logic [2:0] {
        ST_SETTING   = 3'd0,
        ST_RUNNING   = 3'd1,
        ST_SWITCHING = 3'd2,
        ST_DONE      = 3'd3,
        ST_ERROR     = 3'd4,
        ST_FATAL     = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        BEEP_OFF  = 2'd0,
        BEEP_SLOW = 2'd1,
        BEEP_FAST = 2'd2,
        BEEP_CONT = 2'd3
    } beep_t;

    function automatic beep_t beep_for(input state_t s);
        case (s)
            ST_DONE:  return BEEP_SLOW;
            ST_ERROR: return BEEP_FAST;
            ST_FATAL: return BEEP_CONT;
            default:  return BEEP_OFF;
        endcase
    endfunction

endpackage

// File: rtl/sec_timer.sv
// sec_timer: loadable down-counter used as a seconds watchdog.
//   clk, rst  : clock, asynchronous active-high reset (count clears to 0)
//   load      : load load_val this cycle (wins over tick)
//   load_val  : value to load
//   tick      : decrement by one; holds at 0
//   count     : current value
//   zero      : count == 0
module sec_timer
    import pill_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [TIMER_W-1:0] load_val,
    input  logic               tick,
    output logic [TIMER_W-1:0] count,
    output logic               zero
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (tick && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/pill_line_sequencer.sv
// pill_line_sequencer: central sequencer of the pill-bottling line.
// Owns the batch state machine, the pill/bottle counters and two watchdog
// timers (bottle switch time, hopper starvation).
//   clk_1khz, rst        : system clock, asynchronous active-high reset
//   tick_1hz             : one-cycle strobe per second (timer timebase)
//   pill_pulse           : one-cycle strobe per dropped pill
//   start, clr           : operator strobes
//   estop                : emergency stop level
//   conveyor_fault       : conveyor stall level
//   hopper_refill        : operator refilled the hopper (strobe)
//   target_pills/bottles : batch targets, sampled on an accepted start
//   state                : current state code
//   now_pills/bottles    : pills in current bottle / bottles completed
//   hopper_en            : hopper feed enable
//   conveyor_en          : conveyor drive enable
//   beep_mode            : beeper pattern
// All outputs are registered; enables and beep are derived from the next
// state so they change on the same edge as the state.
module pill_line_sequencer
    import pill_pkg::*;
#(
    parameter int SWITCH_TIME = 3,
    parameter int HOP_TIMEOUT = 5
) (
    input  logic                clk_1khz,
    input  logic                rst,
    input  logic                tick_1hz,
    input  logic                pill_pulse,
    input  logic                start,
    input  logic                clr,
    input  logic                estop,
    input  logic                conveyor_fault,
    input  logic                hopper_refill,
    input  logic [PILL_W-1:0]   target_pills,
    input  logic [BOTTLE_W-1:0] target_bottles,
    output logic [2:0]          state,
    output logic [PILL_W-1:0]   now_pills,
    output logic [BOTTLE_W-1:0] now_bottles,
    output logic                hopper_en,
    output logic                conveyor_en,
    output logic [1:0]          beep_mode
);

    localparam logic [TIMER_W-1:0] SW_LOAD  = TIMER_W'(SWITCH_TIME);
    localparam logic [TIMER_W-1:0] HOP_LOAD = TIMER_W'(HOP_TIMEOUT);

    state_t                state_q, state_d;
    logic [PILL_W-1:0]     pills_d, tp_q, tp_d, pills_inc;
    logic [BOTTLE_W-1:0]   bottles_d, tb_q, tb_d;
    logic                  hop_load, hop_tick, sw_load, sw_tick;
    logic [TIMER_W-1:0]    hop_count, sw_count;
    logic                  hop_zero, sw_zero;
    logic                  targets_ok;

    sec_timer u_sw_timer (
        .clk      (clk_1khz),
        .rst      (rst),
        .load     (sw_load),
        .load_val (SW_LOAD),
        .tick     (sw_tick),
        .count    (sw_count),
        .zero     (sw_zero)
    );

    sec_timer u_hop_timer (
        .clk      (clk_1khz),
        .rst      (rst),
        .load     (hop_load),
        .load_val (HOP_LOAD),
        .tick     (hop_tick),
        .count    (hop_count),
        .zero     (hop_zero)
    );

    assign targets_ok = (target_pills != '0) && (target_bottles != '0);
    assign pills_inc  = (now_pills >= PILL_MAX) ? PILL_MAX : now_pills + 1'b1;

    always_comb begin
        state_d   = state_q;
        pills_d   = now_pills;
        bottles_d = now_bottles;
        tp_d      = tp_q;
        tb_d      = tb_q;
        hop_load  = 1'b0;
        hop_tick  = 1'b0;
        sw_load   = 1'b0;
        sw_tick   = 1'b0;
        case (state_q)
            ST_SETTING: begin
                if (start && !estop && targets_ok) begin
                    tp_d      = target_pills;
                    tb_d      = target_bottles;
                    pills_d   = '0;
                    bottles_d = '0;
                    hop_load  = 1'b1;
                    state_d   = ST_RUNNING;
                end
            end
            ST_RUNNING: begin
                if (estop) begin
                    state_d = ST_FATAL;
                end else if (pill_pulse) begin
                    // A pill on the expiry tick still counts and restarts the watchdog.
                    pills_d  = pills_inc;
                    hop_load = 1'b1;
                    if (pills_inc == tp_q) begin
                        bottles_d = now_bottles + 1'b1;
                        sw_load   = 1'b1;
                        state_d   = ST_SWITCHING;
                    end
                end else if (tick_1hz) begin
                    hop_tick = 1'b1;
                    if (hop_count == 4'd1 || hop_zero) state_d = ST_ERROR;
                end
            end
            ST_SWITCHING: begin
                if (estop || conveyor_fault) begin
                    state_d = ST_FATAL;
                end else begin
                    sw_tick = tick_1hz;
                    // Leave on the tick that takes the timer to zero.
                    if ((tick_1hz && sw_count == 4'd1) || sw_zero) begin
                        if (now_bottles == tb_q) begin
                            state_d = ST_DONE;
                        end else begin
                            pills_d  = '0;
                            hop_load = 1'b1;
                            state_d  = ST_RUNNING;
                        end
                    end
                end
            end
            ST_DONE: begin
                if (estop) begin
                    state_d = ST_FATAL;
                end else if (clr) begin
                    pills_d   = '0;
                    bottles_d = '0;
                    state_d   = ST_SETTING;
                end else if (start && targets_ok) begin
                    tp_d      = target_pills;
                    tb_d      = target_bottles;
                    pills_d   = '0;
                    bottles_d = '0;
                    hop_load  = 1'b1;
                    state_d   = ST_RUNNING;
                end
            end
            ST_ERROR: begin
                if (estop) begin
                    state_d = ST_FATAL;
                end else if (clr) begin
                    pills_d   = '0;
                    bottles_d = '0;
                    state_d   = ST_SETTING;
                end else if (hopper_refill) begin
                    hop_load = 1'b1;
                    state_d  = ST_RUNNING;
                end
            end
            ST_FATAL: begin
                if (!estop && clr) begin
                    pills_d   = '0;
                    bottles_d = '0;
                    state_d   = ST_SETTING;
                end
            end
            default: state_d = ST_SETTING;
        endcase
    end

    always_ff @(posedge clk_1khz or posedge rst) begin
        if (rst) begin
            state_q     <= ST_SETTING;
            now_pills   <= '0;
            now_bottles <= '0;
            tp_q        <= '0;
            tb_q        <= '0;
            hopper_en   <= 1'b0;
            conveyor_en <= 1'b0;
            beep_mode   <= BEEP_OFF;
        end else begin
            state_q     <= state_d;
            now_pills   <= pills_d;
            now_bottles <= bottles_d;
            tp_q        <= tp_d;
            tb_q        <= tb_d;
            hopper_en   <= (state_d == ST_RUNNING);
            conveyor_en <= (state_d == ST_SWITCHING);
            beep_mode   <= beep_for(state_d);
        end
    end

    assign state = state_q;

endmodule
